// File: rtl/m65c02_intc_pkg.sv
// Shared types and constants for the M65C02 peripheral interrupt controller.
package m65c02_intc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACKLO = 1'b1
    } vec_state_e;

    localparam logic [1:0] SEL_PND = 2'd0;
    localparam logic [1:0] SEL_MSK = 2'd1;
    localparam logic [1:0] SEL_ISR = 2'd2;
    localparam logic [1:0] SEL_CTL = 2'd3;

    localparam int CTL_GIE   = 0;
    localparam int CTL_SWNMI = 1;

    // One bit per implemented source; unimplemented bits stay zero.
    function automatic logic [7:0] src_mask(input int n);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < n) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/m65c02_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag and 3-bit index.
module m65c02_prio_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0] req_i,
    output logic         valid_o,
    output logic [2:0]   idx_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 3'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 3'(i);
            end else begin
                idx_o   = idx_o;
            end
        end
    end

endmodule

// File: rtl/m65c02_int_ctrl.sv
// Interrupt controller for the M65C02: edge-captured sources, nIRQ/nNMI
// generation and per-source remapping of the IRQ vector fetch.
module m65c02_int_ctrl
    import m65c02_intc_pkg::*;
#(
    parameter int          pN_SRC      = 8,
    parameter logic [15:0] pIRQ_Vector = 16'hFFFE,
    parameter logic [15:0] pVEC_BASE   = 16'hFFE0,
    parameter int          pNMI_PW     = 4
) (
    input  logic              Rst,
    input  logic              Clk,
    input  logic [pN_SRC-1:0] IntReq,
    input  logic              NMIReq,
    input  logic              CE,
    input  logic              WE,
    input  logic [1:0]        Sel,
    input  logic [7:0]        DI,
    output logic [7:0]        DO,
    input  logic              Rd,
    input  logic [15:0]       AO,
    input  logic              Brk,
    output logic [15:0]       VA,
    output logic              nIRQ,
    output logic              nNMI
);

    localparam logic [7:0]  SRC_MASK = src_mask(pN_SRC);
    localparam logic [15:0] VEC_HI   = pIRQ_Vector + 16'h0001;
    localparam logic [3:0]  NMI_PW   = 4'(pNMI_PW);

    vec_state_e  state_q, state_d;
    logic [7:0]  req_prev_q, req_prev_d;
    logic [7:0]  pnd_q, pnd_d;
    logic [7:0]  msk_q, msk_d;
    logic        gie_q, gie_d;
    logic [2:0]  idx_q, idx_d;
    logic        act_q, act_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic [3:0]  nmi_cnt_q, nmi_cnt_d;
    logic        nirq_q, nirq_d;
    logic        nnmi_q, nnmi_d;

    logic [7:0]  int_req_s;
    logic [7:0]  pend_en_s;
    logic        win_vld_s;
    logic [2:0]  win_s;
    logic        req_s;
    logic        wr_s;
    logic        ack_s;
    logic        ack_done_s;
    logic [7:0]  ack_clr_s;
    logic [7:0]  w1c_s;
    logic        nmi_trig_s;

    assign int_req_s = 8'(IntReq) & SRC_MASK;
    assign pend_en_s = pnd_q & msk_q;
    assign req_s     = gie_q & win_vld_s;
    assign wr_s      = CE & WE;
    assign nIRQ      = nirq_q;
    assign nNMI      = nnmi_q;

    m65c02_prio_enc #(
        .W (8)
    ) u_prio (
        .req_i   (pend_en_s),
        .valid_o (win_vld_s),
        .idx_o   (win_s)
    );

    // Vector FSM: remaps the two-byte IRQ vector fetch to the winner's table entry.
    always_comb begin
        state_d    = state_q;
        VA         = AO;
        ack_s      = 1'b0;
        ack_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (Rd && (AO == pIRQ_Vector) && !Brk && req_s) begin
                    ack_s   = 1'b1;
                    VA      = {pVEC_BASE[15:4], win_s, 1'b0};
                    state_d = ACKLO;
                end else begin
                    state_d = IDLE;
                end
            end
            ACKLO: begin
                if (Rd) begin
                    if (AO == VEC_HI) begin
                        VA = {pVEC_BASE[15:4], idx_q, 1'b1};
                    end else begin
                        VA = AO;
                    end
                    ack_done_s = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = ACKLO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register file, pending-bit update and NMI pulse counter next state.
    always_comb begin
        req_prev_d = int_req_s;
        nmi_prev_d = NMIReq;
        ack_clr_s  = ack_s ? (8'h01 << win_s) : 8'h00;
        w1c_s      = (wr_s && (Sel == SEL_PND)) ? DI : 8'h00;
        // A new edge overrides a same-cycle clear of the same bit.
        pnd_d      = ((pnd_q & ~(w1c_s | ack_clr_s)) | (int_req_s & ~req_prev_q)) & SRC_MASK;

        if (wr_s && (Sel == SEL_MSK)) begin
            msk_d = DI & SRC_MASK;
        end else begin
            msk_d = msk_q;
        end

        if (wr_s && (Sel == SEL_CTL)) begin
            gie_d = DI[CTL_GIE];
        end else begin
            gie_d = gie_q;
        end

        if (ack_s) begin
            idx_d = win_s;
            act_d = 1'b1;
        end else if (ack_done_s) begin
            idx_d = idx_q;
            act_d = 1'b0;
        end else begin
            idx_d = idx_q;
            act_d = act_q;
        end

        nmi_trig_s = (NMIReq & ~nmi_prev_q) | (wr_s & (Sel == SEL_CTL) & DI[CTL_SWNMI]);
        if (nmi_cnt_q != 4'd0) begin
            nmi_cnt_d = nmi_cnt_q - 4'd1;
        end else if (nmi_trig_s) begin
            nmi_cnt_d = NMI_PW;
        end else begin
            nmi_cnt_d = 4'd0;
        end

        nnmi_d = (nmi_cnt_d == 4'd0);
        nirq_d = ~req_s;
    end

    // State and register update.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            req_prev_q <= 8'h00;
            pnd_q      <= 8'h00;
            msk_q      <= 8'h00;
            gie_q      <= 1'b0;
            idx_q      <= 3'd0;
            act_q      <= 1'b0;
            nmi_prev_q <= 1'b0;
            nmi_cnt_q  <= 4'd0;
            nirq_q     <= 1'b1;
            nnmi_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_prev_q <= req_prev_d;
            pnd_q      <= pnd_d;
            msk_q      <= msk_d;
            gie_q      <= gie_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_cnt_q  <= nmi_cnt_d;
            nirq_q     <= nirq_d;
            nnmi_q     <= nnmi_d;
        end
    end

    // Register read mux; the bus sees zero except during a read access.
    always_comb begin
        DO = 8'h00;
        if (CE && !WE) begin
            case (Sel)
                SEL_PND: DO = pnd_q;
                SEL_MSK: DO = msk_q;
                SEL_ISR: DO = {act_q, 4'b0000, idx_q};
                SEL_CTL: DO = {7'b0000000, gie_q};
                default: DO = 8'h00;
            endcase
        end else begin
            DO = 8'h00;
        end
    end

endmodule

// File: tb/tb_m65c02_int_ctrl.sv
// Directed, table-driven bench for m65c02_int_ctrl with a mid-operation reset sequence.
module tb_m65c02_int_ctrl;

    logic        Rst;
    logic        Clk;
    logic [7:0]  IntReq;
    logic        NMIReq;
    logic        CE;
    logic        WE;
    logic [1:0]  Sel;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        Rd;
    logic [15:0] AO;
    logic        Brk;
    logic [15:0] VA;
    logic        nIRQ;
    logic        nNMI;

    int tests;
    int failed;

    m65c02_int_ctrl #(
        .pN_SRC      (8),
        .pIRQ_Vector (16'hFFFE),
        .pVEC_BASE   (16'hFFE0),
        .pNMI_PW     (4)
    ) dut (
        .Rst    (Rst),
        .Clk    (Clk),
        .IntReq (IntReq),
        .NMIReq (NMIReq),
        .CE     (CE),
        .WE     (WE),
        .Sel    (Sel),
        .DI     (DI),
        .DO     (DO),
        .Rd     (Rd),
        .AO     (AO),
        .Brk    (Brk),
        .VA     (VA),
        .nIRQ   (nIRQ),
        .nNMI   (nNMI)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    typedef struct {
        logic        ce;
        logic        we;
        logic [1:0]  sel;
        logic [7:0]  di;
        logic        rd;
        logic [15:0] ao;
        logic        brk;
        logic [7:0]  irq;
        logic        nmi;
        logic        chk_do;
        logic [7:0]  exp_do;
        logic [15:0] exp_va;
        logic        exp_nirq;
        logic        exp_nnmi;
    } vec_t;

    function automatic vec_t v(input logic ce, input logic we, input logic [1:0] sel,
                               input logic [7:0] di, input logic rd, input logic [15:0] ao,
                               input logic brk, input logic [7:0] irq, input logic nmi,
                               input logic chk_do, input logic [7:0] exp_do,
                               input logic [15:0] exp_va, input logic exp_nirq,
                               input logic exp_nnmi);
        vec_t r;
        r.ce = ce; r.we = we; r.sel = sel; r.di = di; r.rd = rd; r.ao = ao;
        r.brk = brk; r.irq = irq; r.nmi = nmi; r.chk_do = chk_do; r.exp_do = exp_do;
        r.exp_va = exp_va; r.exp_nirq = exp_nirq; r.exp_nnmi = exp_nnmi;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector for a full cycle and check outputs mid-cycle.
    task automatic apply(input vec_t t, input string tag);
        @(negedge Clk);
        CE = t.ce; WE = t.we; Sel = t.sel; DI = t.di; Rd = t.rd; AO = t.ao;
        Brk = t.brk; IntReq = t.irq; NMIReq = t.nmi;
        #2;
        check({tag, " VA"}, VA, t.exp_va);
        check({tag, " nIRQ"}, {15'd0, nIRQ}, {15'd0, t.exp_nirq});
        check({tag, " nNMI"}, {15'd0, nNMI}, {15'd0, t.exp_nnmi});
        if (t.chk_do) begin
            check({tag, " DO"}, {8'd0, DO}, {8'd0, t.exp_do});
        end
    endtask

    vec_t tbl[40];
    vec_t hs[8];

    initial begin
        tests  = 0;
        failed = 0;
        Rst = 1'b1; IntReq = 8'h00; NMIReq = 1'b0; CE = 1'b0; WE = 1'b0;
        Sel = 2'd0; DI = 8'h00; Rd = 1'b0; AO = 16'h0000; Brk = 1'b0;

        //          ce we sel di     rd ao        brk irq    nmi chk do     va        nirq nnmi
        tbl[0]  = v(1, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 1, 1);
        tbl[1]  = v(1, 0, 1, 8'h00, 0, 16'h1234, 0, 8'h00, 0, 1, 8'h00, 16'h1234, 1, 1);
        tbl[2]  = v(1, 0, 2, 8'h00, 1, 16'hFFFE, 0, 8'h00, 0, 1, 8'h00, 16'hFFFE, 1, 1);
        tbl[3]  = v(1, 0, 3, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 1, 1);
        tbl[4]  = v(1, 1, 1, 8'h0C, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 1, 1);
        tbl[5]  = v(1, 1, 3, 8'h01, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 1, 1);
        tbl[6]  = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h08, 0, 0, 8'h00, 16'h0000, 1, 1);
        tbl[7]  = v(1, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h04, 0, 1, 8'h08, 16'h0000, 1, 1);
        tbl[8]  = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 1);
        tbl[9]  = v(0, 0, 0, 8'h00, 1, 16'hFFFE, 0, 8'h00, 0, 0, 8'h00, 16'hFFE4, 0, 1);
        tbl[10] = v(1, 0, 2, 8'h00, 1, 16'hFFFF, 0, 8'h00, 0, 1, 8'h82, 16'hFFE5, 0, 1);
        tbl[11] = v(1, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h08, 16'h0000, 0, 1);
        tbl[12] = v(1, 0, 2, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h02, 16'h0000, 0, 1);
        tbl[13] = v(0, 0, 0, 8'h00, 1, 16'hFFFE, 1, 8'h00, 0, 0, 8'h00, 16'hFFFE, 0, 1);
        tbl[14] = v(1, 0, 0, 8'h00, 1, 16'hFFFF, 0, 8'h00, 0, 1, 8'h08, 16'hFFFF, 0, 1);
        tbl[15] = v(1, 1, 0, 8'h08, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 1);
        tbl[16] = v(1, 1, 1, 8'h0D, 0, 16'h0000, 0, 8'h01, 0, 0, 8'h00, 16'h0000, 0, 1);
        tbl[17] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1);
        tbl[18] = v(0, 0, 0, 8'h00, 1, 16'hFFFE, 0, 8'h00, 0, 0, 8'h00, 16'hFFE0, 0, 1);
        tbl[19] = v(1, 0, 2, 8'h00, 1, 16'h0200, 0, 8'h00, 0, 1, 8'h80, 16'h0200, 0, 1);
        tbl[20] = v(1, 0, 2, 8'h00, 1, 16'hFFFF, 0, 8'h00, 0, 1, 8'h00, 16'hFFFF, 1, 1);
        tbl[21] = v(1, 1, 0, 8'h01, 0, 16'h0000, 0, 8'h01, 0, 0, 8'h00, 16'h0000, 1, 1);
        tbl[22] = v(1, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h01, 16'h0000, 1, 1);
        tbl[23] = v(1, 1, 1, 8'h00, 1, 16'hFFFE, 0, 8'h00, 0, 0, 8'h00, 16'hFFE0, 0, 1);
        tbl[24] = v(1, 0, 2, 8'h00, 1, 16'hFFFF, 0, 8'h00, 0, 1, 8'h80, 16'hFFE1, 0, 1);
        tbl[25] = v(1, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 1, 1);
        tbl[26] = v(1, 0, 3, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h01, 16'h0000, 1, 1);
        tbl[27] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 1);
        tbl[28] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0);
        tbl[29] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 1, 0);
        tbl[30] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0);
        tbl[31] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0);
        tbl[32] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1);
        tbl[33] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1);
        tbl[34] = v(1, 1, 3, 8'h03, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1);
        tbl[35] = v(1, 0, 3, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h01, 16'h0000, 1, 0);
        tbl[36] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0);
        tbl[37] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0);
        tbl[38] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 0);
        tbl[39] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1);

        // Reset sequence: reach ACKLO with an NMI pulse running and a source still pending.
        hs[0] = v(1, 1, 1, 8'hFF, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1);
        hs[1] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h03, 0, 0, 8'h00, 16'h0000, 1, 1);
        hs[2] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 1, 1);
        hs[3] = v(1, 1, 3, 8'h03, 1, 16'hFFFE, 0, 8'h00, 0, 0, 8'h00, 16'hFFE0, 0, 1);
        hs[4] = v(0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0);
        hs[5] = v(1, 0, 0, 8'h00, 1, 16'hFFFF, 0, 8'h00, 0, 1, 8'h00, 16'hFFFF, 1, 1);
        hs[6] = v(1, 0, 1, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 1, 1);
        hs[7] = v(1, 0, 3, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 1, 1);

        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        for (int i = 0; i < 5; i++) begin
            apply(hs[i], $sformatf("h%0d", i));
        end

        // Asynchronous reset mid-cycle while in ACKLO: outputs must drop back at once.
        Rst = 1'b1;
        CE = 1'b1; WE = 1'b0; Rd = 1'b1; AO = 16'hFFFF;
        #1;
        check("rst VA", VA, 16'hFFFF);
        check("rst nIRQ", {15'd0, nIRQ}, 16'h0001);
        check("rst nNMI", {15'd0, nNMI}, 16'h0001);
        for (int s = 0; s < 4; s++) begin
            Sel = 2'(s);
            #1;
            check($sformatf("rst DO sel%0d", s), {8'd0, DO}, 16'h0000);
        end
        @(negedge Clk);
        Rst = 1'b0;

        for (int i = 5; i < 8; i++) begin
            apply(hs[i], $sformatf("h%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
